uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_select.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit-side arbiter.
//   state_e          : arbiter FSM encoding (IDLE=0, ACK=1, DRAIN=2)
//   ACK_TIMEOUT_DEF  : default number of cycles to wait for TxD_busy after a start
//   IDX_W            : width of requester indices (owner / round-robin pointer)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int ACK_TIMEOUT_DEF = 8;

    // Up to 8 requesters, so a 3-bit index covers every configuration.
    localparam int IDX_W = 3;

endpackage : uart_pkg

// File: rtl/rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
// Combinational round-robin priority selector. Picks the first set bit of req
// searching upward from ptr, wrapping around to bit 0.
//   req     [N-1:0]  in  : request vector
//   ptr     [2:0]    in  : index with highest priority (must be < N)
//   gnt_idx [2:0]    out : index of the selected request (0 when any=0)
//   any              out : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_select
    import uart_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Two searches instead of a rotate: the lowest set index at or above ptr
    // wins; if there is none, the lowest set index overall (the wrap-around).
    // Scanning downward means the last hit is the lowest index.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign gnt_idx = hi_found ? hi_idx : lo_idx;
    assign any     = |req;

endmodule : rr_select

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one async_transmitter between N_REQ byte requesters using round-robin
// priority. A grant latches the winner's byte, pulses req_ready/tx_start for one
// cycle, then waits for TxD_busy to rise (ACK) and fall again (DRAIN).
//
// Handshake: a requester holds req_valid and its req_data byte stable until it
// sees its req_ready bit; the byte is taken at the clock edge where req_ready
// is high. Lowering req_valid before that simply withdraws the request.
//
// Ports
//   clk                      in  : system clock
//   rst_n                    in  : asynchronous active-low reset
//   req_valid [N_REQ-1:0]    in  : per-requester byte pending
//   req_data  [8*N_REQ-1:0]  in  : requester i byte on [8i+7:8i]
//   req_ready [N_REQ-1:0]    out : one-hot, one-cycle acceptance
//   tx_start                 out : TxD_start pulse
//   tx_data   [7:0]          out : TxD_data, held from grant to next grant
//   tx_busy                  in  : TxD_busy
//   owner     [2:0]          out : current / last winner
//   active                   out : FSM not in IDLE
//   ack_err                  out : sticky start-acknowledge timeout flag
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [IDX_W-1:0]   owner,
    output logic               active,
    output logic               ack_err
);

    localparam int             CNT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]   owner_q,     owner_d;
    logic [7:0]         tx_data_q,   tx_data_d;
    logic               tx_start_q,  tx_start_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic               active_q,    active_d;
    logic               ack_err_q,   ack_err_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;

    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [7:0]         gnt_data;
    logic [N_REQ-1:0]   gnt_onehot;
    logic [IDX_W-1:0]   ptr_after_owner;
    logic [CNT_W-1:0]   cnt_inc;

    rr_select #(
        .N (N_REQ)
    ) u_rr_select (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // Winner's byte and one-hot acceptance vector.
    always_comb begin
        gnt_data   = 8'h00;
        gnt_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                gnt_data      = req_data[8*i +: 8];
                gnt_onehot[i] = 1'b1;
            end
        end
    end

    // Priority moves just past the last winner once its transfer is resolved.
    assign ptr_after_owner = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    // Saturating increment of the ACK wait counter.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        tx_data_d   = tx_data_q;
        ack_err_d   = ack_err_q;
        cnt_d       = cnt_q;
        tx_start_d  = 1'b0;
        req_ready_d = '0;

        case (state_q)
            IDLE: begin
                if (gnt_any && !tx_busy) begin
                    state_d     = ACK;
                    owner_d     = gnt_idx;
                    tx_data_d   = gnt_data;
                    req_ready_d = gnt_onehot;
                    tx_start_d  = 1'b1;
                    cnt_d       = '0;
                end
            end
            ACK: begin
                if (tx_busy) begin
                    state_d = DRAIN;
                end else if (cnt_inc == CNT_MAX) begin
                    // Transmitter never acknowledged: drop the byte and move on.
                    state_d   = IDLE;
                    ack_err_d = 1'b1;
                    rr_ptr_d  = ptr_after_owner;
                    cnt_d     = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_after_owner;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered copy of "not IDLE" so active stays glitch-free.
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            tx_data_q   <= 8'h00;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            active_q    <= 1'b0;
            ack_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            req_ready_q <= req_ready_d;
            active_q    <= active_d;
            ack_err_q   <= ack_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign owner     = owner_q;
    assign active    = active_q;
    assign ack_err   = ack_err_q;

endmodule : uart_tx_arbiter
